// File: rtl/call_request_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : call_request_register                                      |
// | Description : Synchronises and debounces cabin, hall-up and hall-down    |
// |               buttons, latches one request bit per level and type,       |
// |               clears bits on service pulses and summarises pending       |
// |               requests (any / highest / lowest / count).                 |
// |               Optional: CALL_CANCEL_EN - a re-press of an active cabin   |
// |               button cancels that cabin request.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module call_request_register #(
   parameter int LEVELS          = 8,
   parameter int DEBOUNCE_CYCLES = 4,
   localparam int LW = $clog2(LEVELS),
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1),
   localparam int CW = $clog2(3 * LEVELS + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [LEVELS-1:0] btn_in,
   input  logic [LEVELS-1:0] btn_up_out,
   input  logic [LEVELS-1:0] btn_down_out,
   input  logic [LEVELS-1:0] inactivate_in_levels,
   input  logic [LEVELS-1:0] inactivate_out_up_levels,
   input  logic [LEVELS-1:0] inactivate_out_down_levels,
   output logic [LEVELS-1:0] active_in_levels,
   output logic [LEVELS-1:0] active_out_up_levels,
   output logic [LEVELS-1:0] active_out_down_levels,
   output logic              req_any,
   output logic [LW-1:0]     req_max_level,
   output logic [LW-1:0]     req_min_level,
   output logic [CW-1:0]     req_count
);

   localparam int                c_bits     = 3 * LEVELS;
   localparam logic [DW-1:0]     c_cnt_last = DW'(DEBOUNCE_CYCLES - 1);
   // Top floor has no up button, ground floor has no down button.
   localparam logic [LEVELS-1:0] c_up_mask  = {1'b0, {(LEVELS-1){1'b1}}};
   localparam logic [LEVELS-1:0] c_dn_mask  = {{(LEVELS-1){1'b1}}, 1'b0};

   logic [c_bits-1:0] w_raw;
   logic [c_bits-1:0] w_rise;
   logic [LEVELS-1:0] w_rise_in;
   logic [LEVELS-1:0] w_rise_up;
   logic [LEVELS-1:0] w_rise_dn;
   logic [LEVELS-1:0] w_in_next;
   logic [LEVELS-1:0] w_all;

   // Boundary buttons are forced low at the source so their chains never toggle.
   assign w_raw = {btn_down_out & c_dn_mask, btn_up_out & c_up_mask, btn_in};

   genvar gi;
   generate
      for (gi = 0; gi < c_bits; gi++) begin : g_debounce
         logic          r_s1;
         logic          r_s2;
         logic          r_db;
         logic [DW-1:0] r_cnt;

         // Two-flop synchroniser followed by a stability counter; db only follows
         // s2 once it has differed for DEBOUNCE_CYCLES consecutive cycles.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_s1  <= 1'b0;
               r_s2  <= 1'b0;
               r_db  <= 1'b0;
               r_cnt <= '0;
            end else begin
               r_s1 <= w_raw[gi];
               r_s2 <= r_s1;
               if (r_s2 == r_db) begin
                  r_cnt <= '0;
               end else if (r_cnt == c_cnt_last) begin
                  r_db  <= r_s2;
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + DW'(1);
               end
            end
         end

         // Debounced 0->1 flip, asserted on the edge where db itself rises.
         assign w_rise[gi] = r_s2 & ~r_db & (r_cnt == c_cnt_last);
      end
   endgenerate

   assign w_rise_in = w_rise[LEVELS-1:0];
   assign w_rise_up = w_rise[2*LEVELS-1:LEVELS];
   assign w_rise_dn = w_rise[3*LEVELS-1:2*LEVELS];

`ifdef CALL_CANCEL_EN
   // A new press toggles the cabin bit; an inactive bit sets (beating a same-edge
   // clear), an active bit clears.
   assign w_in_next = (active_in_levels & ~inactivate_in_levels & ~w_rise_in)
                    | (w_rise_in & ~active_in_levels);
`else
   // Set has priority over a same-edge clear.
   assign w_in_next = (active_in_levels & ~inactivate_in_levels) | w_rise_in;
`endif

   // Request latches: set on debounced rise, clear on service pulse, set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         active_in_levels       <= '0;
         active_out_up_levels   <= '0;
         active_out_down_levels <= '0;
      end else begin
         active_in_levels       <= w_in_next;
         active_out_up_levels   <= ((active_out_up_levels & ~inactivate_out_up_levels)
                                   | w_rise_up) & c_up_mask;
         active_out_down_levels <= ((active_out_down_levels & ~inactivate_out_down_levels)
                                   | w_rise_dn) & c_dn_mask;
      end
   end

   assign w_all   = active_in_levels | active_out_up_levels | active_out_down_levels;
   assign req_any = |w_all;

   // Summary: highest/lowest pending level and total number of pending requests.
   always_comb begin
      req_max_level = '0;
      req_min_level = '0;
      req_count     = '0;
      for (int i = 0; i < LEVELS; i++) begin
         if (w_all[i]) req_max_level = LW'(i);
      end
      for (int i = LEVELS - 1; i >= 0; i--) begin
         if (w_all[i]) req_min_level = LW'(i);
      end
      for (int i = 0; i < LEVELS; i++) begin
         req_count = req_count + CW'(active_in_levels[i])
                               + CW'(active_out_up_levels[i])
                               + CW'(active_out_down_levels[i]);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_call_request_register.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_call_request_register                                   |
// | Description : Directed bench for call_request_register (LEVELS=8,        |
// |               DEBOUNCE_CYCLES=4) with a queued expected-value scoreboard.|
// |               Honours CALL_CANCEL_EN for the cancel expectation.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_call_request_register;

   logic       clk;
   logic       reset;
   logic [7:0] btn_in, btn_up_out, btn_down_out;
   logic [7:0] inact_in, inact_up, inact_dn;
   logic [7:0] act_in, act_up, act_dn;
   logic       req_any;
   logic [2:0] req_max_level, req_min_level;
   logic [4:0] req_count;

   call_request_register #(.LEVELS(8), .DEBOUNCE_CYCLES(4)) dut (
      .clk                        (clk),
      .reset                      (reset),
      .btn_in                     (btn_in),
      .btn_up_out                 (btn_up_out),
      .btn_down_out               (btn_down_out),
      .inactivate_in_levels       (inact_in),
      .inactivate_out_up_levels   (inact_up),
      .inactivate_out_down_levels (inact_dn),
      .active_in_levels           (act_in),
      .active_out_up_levels       (act_up),
      .active_out_down_levels     (act_dn),
      .req_any                    (req_any),
      .req_max_level              (req_max_level),
      .req_min_level              (req_min_level),
      .req_count                  (req_count)
   );

   typedef struct {
      int         due;
      string      name;
      logic [7:0] in;
      logic [7:0] up;
      logic [7:0] dn;
      logic       any;
      logic [2:0] mx;
      logic [2:0] mn;
      logic [4:0] cnt;
   } exp_t;

   exp_t q[$];
   int   cyc     = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising-edge counter; expected entries are scheduled against it.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(exp_t e);
      n_checks++;
      if (act_in === e.in && act_up === e.up && act_dn === e.dn && req_any === e.any &&
          req_max_level === e.mx && req_min_level === e.mn && req_count === e.cnt) begin
         n_pass++;
      end else begin
         $display("FAIL %s @cyc%0d: got in=%h up=%h dn=%h any=%b max=%0d min=%0d cnt=%0d, want in=%h up=%h dn=%h any=%b max=%0d min=%0d cnt=%0d",
                  e.name, cyc, act_in, act_up, act_dn, req_any, req_max_level, req_min_level,
                  req_count, e.in, e.up, e.dn, e.any, e.mx, e.mn, e.cnt);
      end
   endfunction

   // Monitor: on each falling edge compare every entry whose cycle has come.
   always @(negedge clk) begin
      int k;
      k = 0;
      while (k < q.size()) begin
         if (q[k].due <= cyc) begin
            check(q[k]);
            q.delete(k);
         end else begin
            k++;
         end
      end
   end

   task automatic exp_push(input int off, input string nm, input logic [7:0] e_in,
                           input logic [7:0] e_up, input logic [7:0] e_dn, input logic e_any,
                           input logic [2:0] e_mx, input logic [2:0] e_mn, input logic [4:0] e_cnt);
      exp_t e;
      e.due = cyc + off; e.name = nm;
      e.in = e_in; e.up = e_up; e.dn = e_dn;
      e.any = e_any; e.mx = e_mx; e.mn = e_mn; e.cnt = e_cnt;
      q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      btn_in = '0; btn_up_out = '0; btn_down_out = '0;
      inact_in = '0; inact_up = '0; inact_dn = '0;
      tick(2);
      exp_push(1, "reset", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      tick(1);
      reset = 1'b0;
      tick(2);

      // 1: held cabin press registers after exactly six edges.
      btn_in = 8'h08;
      exp_push(5, "t1_pre", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      exp_push(6, "t1_set", 8'h08, 8'h00, 8'h00, 1'b1, 3'd3, 3'd3, 5'd1);
      tick(6);
      btn_in = 8'h00;
      inact_in = 8'h08;
      exp_push(1, "t1_clr", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      tick(1);
      inact_in = 8'h00;
      tick(8);

      // 2: three-cycle glitch is rejected.
      btn_up_out = 8'h20;
      exp_push(6,  "t2_glitch_a", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      exp_push(10, "t2_glitch_b", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      tick(3);
      btn_up_out = 8'h00;
      tick(10);

      // 3: down[6] + in[1], then clear down[6] (count decrements), then in[1].
      btn_down_out = 8'h40; btn_in = 8'h02;
      exp_push(6, "t3_set", 8'h02, 8'h00, 8'h40, 1'b1, 3'd6, 3'd1, 5'd2);
      tick(6);
      btn_down_out = 8'h00; btn_in = 8'h00;
      inact_dn = 8'h40;
      exp_push(1, "t3_clr_dn", 8'h02, 8'h00, 8'h00, 1'b1, 3'd1, 3'd1, 5'd1);
      tick(1);
      inact_dn = 8'h00;
      inact_in = 8'h02;
      exp_push(1, "t3_clr_in", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      tick(1);
      inact_in = 8'h00;
      tick(8);

      // 4: set and clear on the same edge -> set wins; holding does not re-set.
      btn_in = 8'h04;
      exp_push(5, "t4_pre",     8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      exp_push(6, "t4_setwins", 8'h04, 8'h00, 8'h00, 1'b1, 3'd2, 3'd2, 5'd1);
      tick(5);
      inact_in = 8'h04;
      tick(1);
      inact_in = 8'h04;
      exp_push(6, "t4_hold", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      tick(1);
      inact_in = 8'h00;
      tick(5);
      btn_in = 8'h00;
      tick(8);

      // 5: boundary buttons ignored; mixed requests summarised.
      btn_up_out = 8'h90; btn_down_out = 8'h41; btn_in = 8'h02;
      exp_push(6,  "t5_set",  8'h02, 8'h10, 8'h40, 1'b1, 3'd6, 3'd1, 5'd3);
      exp_push(10, "t5_hold", 8'h02, 8'h10, 8'h40, 1'b1, 3'd6, 3'd1, 5'd3);
      tick(10);
      btn_up_out = 8'h00; btn_down_out = 8'h00; btn_in = 8'h00;
      inact_in = 8'h02; inact_up = 8'h10; inact_dn = 8'h40;
      exp_push(1, "t5_clr", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      tick(1);
      inact_in = 8'h00; inact_up = 8'h00; inact_dn = 8'h00;
      tick(8);

      // 6: asynchronous reset between edges, with a request active and a press mid-debounce.
      btn_up_out = 8'h04;
      exp_push(6, "t6_up", 8'h00, 8'h04, 8'h00, 1'b1, 3'd2, 3'd2, 5'd1);
      tick(6);
      btn_in = 8'h08;
      tick(3);
      exp_push(1, "t6_async", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      @(posedge clk);
      #1 reset = 1'b1;
      #2 reset = 1'b0;
      @(negedge clk);
      exp_push(5, "t6_pre",   8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      exp_push(6, "t6_rereg", 8'h08, 8'h04, 8'h00, 1'b1, 3'd3, 3'd2, 5'd2);
      tick(6);
      btn_in = 8'h00;
      tick(8);
      btn_in = 8'h08;
`ifdef CALL_CANCEL_EN
      exp_push(6, "t6_repress", 8'h00, 8'h04, 8'h00, 1'b1, 3'd2, 3'd2, 5'd1);
`else
      exp_push(6, "t6_repress", 8'h08, 8'h04, 8'h00, 1'b1, 3'd3, 3'd2, 5'd2);
`endif
      tick(6);
      btn_in = 8'h00; btn_up_out = 8'h00;
      inact_in = 8'h08; inact_up = 8'h04;
      exp_push(1, "final_clr", 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 3'd0, 5'd0);
      tick(1);
      inact_in = 8'h00; inact_up = 8'h00;

      for (int k = 0; k < 50 && q.size() > 0; k++) tick(1);
      while (q.size() > 0) begin
         n_checks++;
         $display("FAIL %s: never compared, due cyc%0d, now cyc%0d", q[0].name, q[0].due, cyc);
         void'(q.pop_front());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
